// File: rtl/unzip_vga_str.sv
// unzip_vga_str: delays the packed 23-bit VGA stream by DELAY pixel clocks, unpacks it and
// derives line/frame/first-pixel pulses, a wrapping frame counter and a sticky protocol-error flag.
module unzip_vga_str #(
  parameter int DELAY           = 1,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int FRAME_CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [22:0]            strVGA,
  output logic [9:0]             x_px,
  output logic [9:0]             y_px,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   activevideo,
  output logic                   line_start,
  output logic                   frame_start,
  output logic                   first_px,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   str_err
);

  localparam logic        SYNC_IDLE  = SYNC_ACTIVE_LOW;
  localparam logic [22:0] RESET_WORD = {10'd0, 10'd0, SYNC_IDLE, SYNC_IDLE, 1'b0};

  logic [22:0] pipe_reg  [DELAY];
  logic [22:0] pipe_next [DELAY];

  genvar gi;
  generate
    for (gi = 0; gi < DELAY; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign pipe_next[gi] = strVGA;
      end else begin : g_tail
        assign pipe_next[gi] = pipe_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DELAY; i++) begin
      if (reset) pipe_reg[i] <= RESET_WORD;
      else       pipe_reg[i] <= pipe_next[i];
    end
  end

  assign {x_px, y_px, hsync, vsync, activevideo} = pipe_reg[DELAY-1];

  // Sync levels normalised so that 1 always means "asserted", whatever the wire polarity.
  logic hs_on, vs_on;
  assign hs_on = hsync ^ SYNC_ACTIVE_LOW;
  assign vs_on = vsync ^ SYNC_ACTIVE_LOW;

  logic hs_prev_reg, vs_prev_reg, act_prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_prev_reg  <= 1'b0;
      vs_prev_reg  <= 1'b0;
      act_prev_reg <= 1'b0;
    end else begin
      hs_prev_reg  <= hs_on;
      vs_prev_reg  <= vs_on;
      act_prev_reg <= activevideo;
    end
  end

  assign line_start  = hs_on & ~hs_prev_reg;
  assign frame_start = vs_on & ~vs_prev_reg;
  assign first_px    = activevideo & ~act_prev_reg & (y_px == 10'd0);

  logic [FRAME_CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic                   str_err_reg, str_err_next;

  always_comb begin
    frame_cnt_next = frame_cnt_reg;
    str_err_next   = str_err_reg;
    if (frame_start) frame_cnt_next = frame_cnt_reg + FRAME_CNT_W'(1);
    // Video is never legal inside a sync interval; once seen, keep the flag until reset.
    if (activevideo && (hs_on || vs_on)) str_err_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_reg <= '0;
      str_err_reg   <= 1'b0;
    end else begin
      frame_cnt_reg <= frame_cnt_next;
      str_err_reg   <= str_err_next;
    end
  end

  assign frame_cnt = frame_cnt_reg;
  assign str_err   = str_err_reg;

endmodule

// File: tb/tb_unzip_vga_str.sv
// Directed bench for unzip_vga_str: four instances (DELAY 1/4/3 active-low, DELAY 2 active-high)
// checked for latency, edge pulses, frame counting/wrap, sticky error and mid-line reset.
module tb_unzip_vga_str;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [22:0] str;
  logic [22:0] str_h;

  // index 0: DELAY=1, 1: DELAY=4 (FRAME_CNT_W=2), 2: DELAY=3, 3: DELAY=2 active-high sync
  logic [9:0] xo  [4];
  logic [9:0] yo  [4];
  logic       hso [4];
  logic       vso [4];
  logic       act [4];
  logic       lso [4];
  logic       fso [4];
  logic       fpo [4];
  logic       err [4];
  logic [7:0] fc0, fc2, fc3;
  logic [1:0] fc1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  unzip_vga_str #(.DELAY(1), .SYNC_ACTIVE_LOW(1'b1), .FRAME_CNT_W(8)) u_d1 (
    .clk(clk), .reset(reset), .strVGA(str), .x_px(xo[0]), .y_px(yo[0]), .hsync(hso[0]),
    .vsync(vso[0]), .activevideo(act[0]), .line_start(lso[0]), .frame_start(fso[0]),
    .first_px(fpo[0]), .frame_cnt(fc0), .str_err(err[0]));

  unzip_vga_str #(.DELAY(4), .SYNC_ACTIVE_LOW(1'b1), .FRAME_CNT_W(2)) u_d4 (
    .clk(clk), .reset(reset), .strVGA(str), .x_px(xo[1]), .y_px(yo[1]), .hsync(hso[1]),
    .vsync(vso[1]), .activevideo(act[1]), .line_start(lso[1]), .frame_start(fso[1]),
    .first_px(fpo[1]), .frame_cnt(fc1), .str_err(err[1]));

  unzip_vga_str #(.DELAY(3), .SYNC_ACTIVE_LOW(1'b1), .FRAME_CNT_W(8)) u_d3 (
    .clk(clk), .reset(reset), .strVGA(str), .x_px(xo[2]), .y_px(yo[2]), .hsync(hso[2]),
    .vsync(vso[2]), .activevideo(act[2]), .line_start(lso[2]), .frame_start(fso[2]),
    .first_px(fpo[2]), .frame_cnt(fc2), .str_err(err[2]));

  unzip_vga_str #(.DELAY(2), .SYNC_ACTIVE_LOW(1'b0), .FRAME_CNT_W(8)) u_dh (
    .clk(clk), .reset(reset), .strVGA(str_h), .x_px(xo[3]), .y_px(yo[3]), .hsync(hso[3]),
    .vsync(vso[3]), .activevideo(act[3]), .line_start(lso[3]), .frame_start(fso[3]),
    .first_px(fpo[3]), .frame_cnt(fc3), .str_err(err[3]));

  function automatic logic [22:0] mk(int x, int y, logic hs, logic vs, logic av);
    return {10'(x), 10'(y), hs, vs, av};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // frame statistics collected by run_frames
  int fs_cnt [2];
  int ls_cnt [2];
  int fp_cnt [2];
  int fp_bad;
  int cyc;
  int stamps [$];
  int seq0 [$];
  int seq1 [$];
  logic fs_d [2];

  task automatic sample_frame();
    cyc++;
    if (fso[0]) stamps.push_back(cyc);
    if (fs_d[0]) seq0.push_back(int'(fc0));
    if (fs_d[1]) seq1.push_back(int'(fc1));
    for (int k = 0; k < 2; k++) begin
      if (fso[k]) fs_cnt[k]++;
      if (lso[k]) ls_cnt[k]++;
      if (fpo[k]) fp_cnt[k]++;
      if (fpo[k] && (xo[k] != 10'd0 || yo[k] != 10'd0)) fp_bad++;
      fs_d[k] = fso[k];
    end
  endtask

  // Scaled-down raster: 10 clocks/line, 6 lines/frame, 6x4 active, hsync low x=7..8, vsync low y=5
  task automatic run_frames(input int n);
    for (int k = 0; k < 2; k++) begin
      fs_cnt[k] = 0; ls_cnt[k] = 0; fp_cnt[k] = 0; fs_d[k] = 1'b0;
    end
    fp_bad = 0; cyc = 0;
    stamps.delete(); seq0.delete(); seq1.delete();
    for (int f = 0; f < n; f++)
      for (int y = 0; y < 6; y++)
        for (int x = 0; x < 10; x++) begin
          str = mk(x, y, !(x == 7 || x == 8), !(y == 5), (x < 6 && y < 4));
          tick();
          sample_frame();
        end
    str = mk(0, 0, 1'b1, 1'b1, 1'b0);
    for (int d = 0; d < 6; d++) begin
      tick();
      sample_frame();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    str   = mk(0, 0, 1'b1, 1'b1, 1'b0);
    str_h = mk(0, 0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      tests++; if (xo[i] !== 10'd0) begin fails++; $display("FAIL reset_x[%0d]: got %0d want 0", i, xo[i]); end
      tests++; if (yo[i] !== 10'd0) begin fails++; $display("FAIL reset_y[%0d]: got %0d want 0", i, yo[i]); end
      tests++; if (hso[i] !== (i != 3)) begin fails++; $display("FAIL reset_hsync[%0d]: got %b want %b", i, hso[i], (i != 3)); end
      tests++; if (vso[i] !== (i != 3)) begin fails++; $display("FAIL reset_vsync[%0d]: got %b want %b", i, vso[i], (i != 3)); end
      tests++; if ({act[i], lso[i], fso[i], fpo[i], err[i]} !== 5'b0) begin
        fails++; $display("FAIL reset_flags[%0d]: got %b want 00000", i, {act[i], lso[i], fso[i], fpo[i], err[i]});
      end
    end
    tests++; if ({fc0, fc1, fc2, fc3} !== 26'd0) begin fails++; $display("FAIL reset_cnt: got %h want 0", {fc0, fc1, fc2, fc3}); end
    reset = 1'b0;
    tick();
    $display("[TB] test_reset done");
  endtask

  task automatic test_delay();
    str = mk(5, 7, 1'b1, 1'b1, 1'b1);
    tick();
    tests++; if (xo[0] !== 10'd5) begin fails++; $display("FAIL d1_x: got %0d want 5", xo[0]); end
    tests++; if (yo[0] !== 10'd7) begin fails++; $display("FAIL d1_y: got %0d want 7", yo[0]); end
    tests++; if (act[0] !== 1'b1) begin fails++; $display("FAIL d1_act: got %b want 1", act[0]); end
    tests++; if (fpo[0] !== 1'b0) begin fails++; $display("FAIL d1_first_px_y7: got %b want 0", fpo[0]); end
    tick(); tick();
    tests++; if (xo[1] !== 10'd0) begin fails++; $display("FAIL d4_early_x: got %0d want 0", xo[1]); end
    tick();
    tests++; if (xo[1] !== 10'd5 || act[1] !== 1'b1) begin fails++; $display("FAIL d4_x: got %0d/%b want 5/1", xo[1], act[1]); end
    tests++; if (xo[0] !== 10'd5 || yo[0] !== 10'd7) begin fails++; $display("FAIL d1_hold: got %0d,%0d want 5,7", xo[0], yo[0]); end
    $display("[TB] test_delay done");
  endtask

  task automatic test_line_start();
    int extra;
    str = mk(5, 7, 1'b0, 1'b1, 1'b0);
    tick();
    tests++; if (hso[0] !== 1'b0 || lso[0] !== 1'b1) begin fails++; $display("FAIL d1_ls: got hs=%b ls=%b want 0/1", hso[0], lso[0]); end
    tick(); tick();
    tests++; if (hso[1] !== 1'b1 || lso[1] !== 1'b0) begin fails++; $display("FAIL d4_ls_early: got hs=%b ls=%b want 1/0", hso[1], lso[1]); end
    tick();
    tests++; if (hso[1] !== 1'b0 || lso[1] !== 1'b1) begin fails++; $display("FAIL d4_ls: got hs=%b ls=%b want 0/1", hso[1], lso[1]); end
    tick();
    tests++; if (hso[1] !== 1'b0 || lso[1] !== 1'b0) begin fails++; $display("FAIL d4_ls_width: got hs=%b ls=%b want 0/0", hso[1], lso[1]); end
    str = mk(5, 7, 1'b1, 1'b1, 1'b0);
    extra = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (lso[1]) extra++;
    end
    tests++; if (extra !== 0 || hso[1] !== 1'b1) begin fails++; $display("FAIL d4_ls_release: got pulses=%0d hs=%b want 0/1", extra, hso[1]); end
    $display("[TB] test_line_start done");
  endtask

  task automatic test_frames();
    int exp1 [5];
    exp1 = '{1, 2, 3, 0, 1};
    run_frames(5);
    for (int k = 0; k < 2; k++) begin
      tests++; if (fs_cnt[k] !== 5) begin fails++; $display("FAIL frame_starts[%0d]: got %0d want 5", k, fs_cnt[k]); end
      tests++; if (ls_cnt[k] !== 30) begin fails++; $display("FAIL line_starts[%0d]: got %0d want 30", k, ls_cnt[k]); end
      tests++; if (fp_cnt[k] !== 5) begin fails++; $display("FAIL first_px[%0d]: got %0d want 5", k, fp_cnt[k]); end
      tests++; if (err[k] !== 1'b0) begin fails++; $display("FAIL frames_err[%0d]: got %b want 0", k, err[k]); end
    end
    tests++; if (fp_bad !== 0) begin fails++; $display("FAIL first_px_pos: got %0d off-origin pulses want 0", fp_bad); end
    for (int i = 1; i < 5; i++) begin
      tests++; if (i >= stamps.size() || stamps[i] - stamps[i-1] !== 60) begin
        fails++; $display("FAIL frame_period[%0d]: got %0d want 60", i, (i < stamps.size()) ? stamps[i] - stamps[i-1] : -1);
      end
    end
    for (int i = 0; i < 5; i++) begin
      tests++; if (i >= seq0.size() || seq0[i] !== i + 1) begin
        fails++; $display("FAIL cnt8[%0d]: got %0d want %0d", i, (i < seq0.size()) ? seq0[i] : -1, i + 1);
      end
      tests++; if (i >= seq1.size() || seq1[i] !== exp1[i]) begin
        fails++; $display("FAIL cnt2_wrap[%0d]: got %0d want %0d", i, (i < seq1.size()) ? seq1[i] : -1, exp1[i]);
      end
    end
    $display("[TB] test_frames done");
  endtask

  task automatic test_error();
    str = mk(1, 2, 1'b1, 1'b0, 1'b1);
    tick();
    str = mk(0, 0, 1'b1, 1'b1, 1'b0);
    tests++; if (err[0] !== 1'b0 || act[0] !== 1'b1) begin fails++; $display("FAIL d1_err_early: got err=%b act=%b want 0/1", err[0], act[0]); end
    tick();
    tests++; if (err[0] !== 1'b1) begin fails++; $display("FAIL d1_err_set: got %b want 1", err[0]); end
    tick(); tick();
    tests++; if (err[1] !== 1'b0) begin fails++; $display("FAIL d4_err_early: got %b want 0", err[1]); end
    tests++; if (err[2] !== 1'b1) begin fails++; $display("FAIL d3_err_set: got %b want 1", err[2]); end
    tick();
    tests++; if (err[1] !== 1'b1) begin fails++; $display("FAIL d4_err_set: got %b want 1", err[1]); end
    run_frames(1);
    tests++; if ({err[0], err[1], err[2]} !== 3'b111) begin fails++; $display("FAIL err_sticky: got %b want 111", {err[0], err[1], err[2]}); end
    $display("[TB] test_error done");
  endtask

  task automatic test_reset_mid();
    for (int x = 0; x < 5; x++) begin
      str = mk(x, 1, 1'b1, 1'b1, 1'b1);
      tick();
    end
    reset = 1'b1;
    str = mk(5, 1, 1'b1, 1'b1, 1'b1);
    tick();
    tests++; if (xo[2] !== 10'd0 || yo[2] !== 10'd0) begin fails++; $display("FAIL mid_xy: got %0d,%0d want 0,0", xo[2], yo[2]); end
    tests++; if (hso[2] !== 1'b1 || vso[2] !== 1'b1) begin fails++; $display("FAIL mid_sync: got %b%b want 11", hso[2], vso[2]); end
    tests++; if ({act[2], lso[2], fso[2], fpo[2], err[2], err[0]} !== 6'b0) begin
      fails++; $display("FAIL mid_flags: got %b want 000000", {act[2], lso[2], fso[2], fpo[2], err[2], err[0]});
    end
    tests++; if (fc2 !== 8'd0) begin fails++; $display("FAIL mid_cnt: got %0d want 0", fc2); end
    reset = 1'b0;
    for (int t = 0; t < 2; t++) begin
      str = mk(6 + t, 1, 1'b1, 1'b1, 1'b1);
      tick();
      tests++; if ({act[2], xo[2], lso[2], fso[2], fpo[2]} !== 14'd0) begin
        fails++; $display("FAIL mid_refill[%0d]: got act=%b x=%0d pulses=%b%b%b want 0", t, act[2], xo[2], lso[2], fso[2], fpo[2]);
      end
    end
    str = mk(8, 1, 1'b1, 1'b1, 1'b1);
    tick();
    tests++; if (xo[2] !== 10'd6 || yo[2] !== 10'd1 || act[2] !== 1'b1) begin
      fails++; $display("FAIL mid_resume: got x=%0d y=%0d act=%b want 6,1,1", xo[2], yo[2], act[2]);
    end
    tests++; if ({lso[2], fso[2], fpo[2], err[2]} !== 4'b0) begin fails++; $display("FAIL mid_spurious: got %b want 0000", {lso[2], fso[2], fpo[2], err[2]}); end
    $display("[TB] test_reset_mid done");
  endtask

  task automatic test_polarity();
    str_h = mk(3, 0, 1'b1, 1'b1, 1'b0);
    tick();
    tests++; if (hso[3] !== 1'b0 || lso[3] !== 1'b0 || fso[3] !== 1'b0) begin fails++; $display("FAIL ah_early: got hs=%b ls=%b fs=%b want 000", hso[3], lso[3], fso[3]); end
    tick();
    tests++; if (hso[3] !== 1'b1 || vso[3] !== 1'b1) begin fails++; $display("FAIL ah_sync: got %b%b want 11", hso[3], vso[3]); end
    tests++; if (lso[3] !== 1'b1 || fso[3] !== 1'b1) begin fails++; $display("FAIL ah_both_edges: got ls=%b fs=%b want 1/1", lso[3], fso[3]); end
    str_h = mk(3, 0, 1'b0, 1'b0, 1'b1);
    tick();
    tests++; if (lso[3] !== 1'b0 || fso[3] !== 1'b0 || fc3 !== 8'd1) begin fails++; $display("FAIL ah_after: got ls=%b fs=%b cnt=%0d want 0/0/1", lso[3], fso[3], fc3); end
    tick();
    tests++; if (fpo[3] !== 1'b1 || act[3] !== 1'b1 || hso[3] !== 1'b0) begin fails++; $display("FAIL ah_first_px: got fp=%b act=%b hs=%b want 1/1/0", fpo[3], act[3], hso[3]); end
    tick();
    tests++; if (err[3] !== 1'b0) begin fails++; $display("FAIL ah_no_err: got %b want 0", err[3]); end
    str_h = mk(3, 0, 1'b1, 1'b0, 1'b1);
    tick(); tick();
    tests++; if (err[3] !== 1'b0 || lso[3] !== 1'b1) begin fails++; $display("FAIL ah_err_early: got err=%b ls=%b want 0/1", err[3], lso[3]); end
    tick();
    tests++; if (err[3] !== 1'b1) begin fails++; $display("FAIL ah_err_set: got %b want 1", err[3]); end
    $display("[TB] test_polarity done");
  endtask

  initial begin
    str   = '0;
    str_h = '0;
    test_reset();
    test_delay();
    test_line_start();
    test_frames();
    test_error();
    test_reset_mid();
    test_polarity();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
